// File: rtl/uart_hex_printer.sv
// Renders a binary word as ASCII hex ("0x" prefix and CR LF optional) and hands the
// characters one at a time to the UART transmitter over its start/finish handshake.
module uart_hex_printer #(
    parameter int WORD_WIDTH = 32,
    parameter int PREFIX     = 1,
    parameter int NEWLINE    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] word,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  busy,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_finish
);

    // state | meaning
    // IDLE  | no message in progress, word_ready high
    // SEND  | single cycle, tx_start high with the current character on tx_data
    // WAIT  | character handed off, waiting for tx_finish from the transmitter

    localparam int NIBBLES = WORD_WIDTH / 4;
    localparam int PRE_LEN = 2 * PREFIX;
    localparam int MSG_LEN = PRE_LEN + NIBBLES + 2 * NEWLINE;
    localparam int IDX_W   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h37 + {4'h0, nib};
    endfunction

    function automatic logic [7:0] char_at(input logic [WORD_WIDTH-1:0] w, input int i);
        if (PREFIX != 0 && i == 0) return 8'h30;
        if (PREFIX != 0 && i == 1) return 8'h78;
        if (i < PRE_LEN + NIBBLES)
            return hex_char(4'(w >> (4 * (PRE_LEN + NIBBLES - 1 - i))));
        if (i == PRE_LEN + NIBBLES) return 8'h0D;
        return 8'h0A;
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (word_valid) begin
                    word_d     = word;
                    idx_d      = '0;
                    tx_data_d  = char_at(word, 0);
                    tx_start_d = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_finish) begin
                    if (idx_q == IDX_W'(MSG_LEN - 1)) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        // Load the next character on the way into SEND so it is valid with tx_start.
                        idx_d      = idx_q + IDX_W'(1);
                        tx_data_d  = char_at(word_q, int'(idx_q) + 1);
                        tx_start_d = 1'b1;
                        state_d    = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign word_ready = (state_q == ST_IDLE) && !reset;
    assign busy       = (state_q != ST_IDLE);
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;

endmodule

// File: tb/tb_uart_hex_printer.sv
// Self-checking bench for uart_hex_printer: a transmitter model answers each start with a
// delayed finish, and the characters seen are compared against a hex-rendering reference.
module tb_uart_hex_printer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] word;
    logic        word_valid, word_ready, busy, tx_start, tx_finish;
    logic [7:0]  tx_data;

    logic [7:0]  w8, d8;
    logic        v8, r8, b8, s8, f8;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    uart_hex_printer dut (
        .clk(clk), .reset(reset), .word(word), .word_valid(word_valid),
        .word_ready(word_ready), .busy(busy), .tx_data(tx_data),
        .tx_start(tx_start), .tx_finish(tx_finish)
    );

    uart_hex_printer #(.WORD_WIDTH(8), .PREFIX(0), .NEWLINE(0)) dut8 (
        .clk(clk), .reset(reset), .word(w8), .word_valid(v8),
        .word_ready(r8), .busy(b8), .tx_data(d8),
        .tx_start(s8), .tx_finish(f8)
    );

    // Reference: the printed text of a word, built from ASCII arithmetic.
    task automatic build_exp(input logic [31:0] w, input int nib, input bit pre, input bit nl);
        int d;
        exp_q.delete();
        if (pre) begin
            exp_q.push_back(8'h30);
            exp_q.push_back(8'h78);
        end
        for (int k = 0; k < nib; k++) begin
            d = int'((w >> (4 * (nib - 1 - k))) & 32'hF);
            exp_q.push_back(d < 10 ? 8'(8'h30 + d) : 8'(8'h41 + d - 10));
        end
        if (nl) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        @(negedge clk);
        n_tests++;
        if (word_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_send: word_ready=%b expected 1", word_ready);
        end
        word       = w;
        word_valid = 1'b1;
        tx_finish  = 1'b0;
    endtask

    // Plays the transmitter for one message and checks every character against exp_q.
    task automatic collect(input string name, input int delay, input bit hold,
                           input bit swap, input int spur_at);
        int  starts, countdown, fin_cycle;
        bit  prev_start, done;
        logic [7:0] held;
        starts = 0; countdown = 0; fin_cycle = -10; prev_start = 0; done = 0; held = 8'h00;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if (!hold) word_valid = 1'b0;
            tx_finish = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    tx_finish = 1'b1;
                    fin_cycle = c;
                end
            end
            if (starts > 0 && starts == exp_q.size() && fin_cycle == c - 1) begin
                n_tests++;
                if (word_ready !== 1'b1 || busy !== 1'b0 || tx_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s end: ready=%b busy=%b start=%b expected 1 0 0",
                             name, word_ready, busy, tx_start);
                end
                done = 1;
            end else if (tx_start === 1'b1) begin
                n_tests++;
                if (prev_start) begin
                    n_fail++;
                    $display("FAIL %s consecutive_start: char %0d", name, starts);
                end
                n_tests++;
                if ((starts == 0 && c != 0) || (starts > 0 && c != fin_cycle + 1)) begin
                    n_fail++;
                    $display("FAIL %s start_timing: char %0d at cycle %0d, last finish %0d",
                             name, starts, c, fin_cycle);
                end
                n_tests++;
                if (starts >= exp_q.size()) begin
                    n_fail++;
                    $display("FAIL %s extra_start: got %0d starts expected %0d",
                             name, starts + 1, exp_q.size());
                end else if (tx_data !== exp_q[starts]) begin
                    n_fail++;
                    $display("FAIL %s char%0d: got %h expected %h",
                             name, starts, tx_data, exp_q[starts]);
                end
                held      = tx_data;
                starts++;
                countdown = delay;
                if (starts - 1 == spur_at) tx_finish = 1'b1;
                if (swap && starts == 1) word = 32'hFFFF_FFFF;
            end else if (starts > 0) begin
                n_tests++;
                if (tx_data !== held || busy !== 1'b1 || word_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s wait_hold: data=%h busy=%b ready=%b expected %h 1 0",
                             name, tx_data, busy, word_ready, held);
                end
            end
            prev_start = tx_start;
        end
        n_tests++;
        if (!done || starts != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s completion: %0d starts seen expected %0d (done=%0d)",
                     name, starts, exp_q.size(), done);
        end
        tx_finish = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; word = '0; word_valid = 1'b0; tx_finish = 1'b0;
        w8 = '0; v8 = 1'b0; f8 = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (word_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: word_ready=%b expected 0", word_ready);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || word_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: start=%b data=%h busy=%b ready=%b expected 0 00 0 1",
                     tx_start, tx_data, busy, word_ready);
        end
    endtask

    task automatic test_default_word();
        build_exp(32'h1234_ABCD, 8, 1, 1);
        send_word(32'h1234_ABCD);
        collect("default", 20, 0, 0, -1);
    endtask

    task automatic test_narrow();
        int starts, countdown, fin_cycle;
        bit done;
        build_exp(32'h0F, 2, 0, 0);
        starts = 0; countdown = 0; fin_cycle = -10; done = 0;
        @(negedge clk);
        w8 = 8'h0F; v8 = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            v8 = 1'b0;
            f8 = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    f8 = 1'b1;
                    fin_cycle = c;
                end
            end
            if (starts == 2 && fin_cycle == c - 1) begin
                n_tests++;
                if (b8 !== 1'b0 || r8 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL narrow_end: busy=%b ready=%b expected 0 1", b8, r8);
                end
                done = 1;
            end else if (s8 === 1'b1) begin
                n_tests++;
                if (starts >= 2 || d8 !== exp_q[starts]) begin
                    n_fail++;
                    $display("FAIL narrow_char%0d: got %h expected %h",
                             starts, d8, starts < 2 ? exp_q[starts] : 8'hxx);
                end
                starts++;
                countdown = 4;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL narrow_completion: %0d starts seen expected 2", starts);
        end
        f8 = 1'b0;
    endtask

    task automatic test_back_to_back();
        build_exp(32'h0000_0000, 8, 1, 1);
        send_word(32'h0000_0000);
        collect("b2b_first", 5, 1, 1, -1);
        build_exp(32'hFFFF_FFFF, 8, 1, 1);
        collect("b2b_second", 5, 0, 0, -1);
    endtask

    task automatic test_spurious();
        repeat (3) begin
            @(negedge clk);
            tx_finish = 1'b1;
            @(negedge clk);
            tx_finish = 1'b0;
            n_tests++;
            if (tx_start !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL spurious_idle: start=%b busy=%b ready=%b expected 0 0 1",
                         tx_start, busy, word_ready);
            end
        end
        build_exp(32'hC0FF_EE42, 8, 1, 1);
        send_word(32'hC0FF_EE42);
        collect("spurious_send0", 3, 0, 0, 0);
        build_exp(32'h5A5A_1234, 8, 1, 1);
        send_word(32'h5A5A_1234);
        collect("spurious_send6", 3, 0, 0, 6);
    endtask

    task automatic test_reset_mid();
        int starts, countdown;
        bit fired;
        starts = 0; countdown = 0; fired = 0;
        send_word(32'hDEAD_BEEF);
        for (int c = 0; c < 1000 && !fired; c++) begin
            @(negedge clk);
            word_valid = 1'b0;
            tx_finish  = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) tx_finish = 1'b1;
            end
            if (tx_start === 1'b1) begin
                starts++;
                countdown = 20;
            end else if (starts == 5 && countdown == 10) begin
                reset = 1'b1;
                fired = 1;
            end
        end
        n_tests++;
        if (!fired) begin
            n_fail++;
            $display("FAIL reset_mid_reach: only %0d starts seen expected 5", starts);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || word_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_state: start=%b data=%h busy=%b ready=%b expected 0 00 0 1",
                     tx_start, tx_data, busy, word_ready);
        end
        build_exp(32'h0000_0001, 8, 1, 1);
        send_word(32'h0000_0001);
        collect("after_reset", 3, 0, 0, -1);
    endtask

    task automatic test_fast();
        build_exp(32'h89AB_CDEF, 8, 1, 1);
        send_word(32'h89AB_CDEF);
        collect("fast", 1, 0, 0, -1);
    endtask

    task automatic test_random();
        logic [31:0] w;
        int delay, spur;
        for (int i = 0; i < 5; i++) begin
            w     = $urandom;
            delay = $urandom_range(1, 6);
            spur  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 11) : -1;
            build_exp(w, 8, 1, 1);
            send_word(w);
            collect("random", delay, 0, 0, spur);
        end
    endtask

    initial begin
        test_reset();
        test_default_word();
        test_narrow();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        test_fast();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
